// File: rtl/mips_pipe_pkg.sv
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared types and constants for the MIPS pipeline control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer only matters when it writes a real (non-$0) register.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] wr,
                                     input logic [4:0] src);
        return we && (wr != REG_ZERO) && (wr == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_seq.sv
// ============================================================================
//  Module      : md_seq
//  Description : Mult/div latency sequencer; busy for LAT cycles, done pulse
//                on the last busy cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_seq
    import mips_pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    md_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // FSM leaves BUSY one cycle early; the done cycle is the final busy cycle,
    // which also lets a new start be accepted back-to-back.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (start) begin
                    w_cnt_nxt   = is_div ? C_DIV_LOAD : C_MUL_LOAD;
                    w_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                w_cnt_nxt = r_cnt - C_CNT_ONE;
                if (r_cnt == C_CNT_ONE) begin
                    w_state_nxt = MD_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == MD_BUSY) || w_done_nxt;
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : 5-stage MIPS hazard/forwarding control with mult/div stall.
//                Optional stall/flush counters under HAZ_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemToRegE,
    input  logic        MemToRegM,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic        MdOpD,
    input  logic        MdStartE,
    input  logic        MdIsDivE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] LwStallCnt,
    output logic [31:0] BrStallCnt,
    output logic [31:0] MdStallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic        MdBusy,
    output logic        MdDone
);

    logic w_lwstall, w_brstall, w_mdstall, w_stall;

    md_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (MdStartE),
        .is_div (MdIsDivE),
        .busy   (MdBusy),
        .done   (MdDone)
    );

    always_comb begin
        ForwardAE = FWD_RF;
        if      (reg_hit(RegWriteM, WriteRegM, RsE)) ForwardAE = FWD_M;
        else if (reg_hit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_W;
        ForwardBE = FWD_RF;
        if      (reg_hit(RegWriteM, WriteRegM, RtE)) ForwardBE = FWD_M;
        else if (reg_hit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_W;
    end

    assign ForwardAD = reg_hit(RegWriteM, WriteRegM, RsD);
    assign ForwardBD = reg_hit(RegWriteM, WriteRegM, RtD);

    assign w_lwstall = reg_hit(MemToRegE, WriteRegE, RsD) || reg_hit(MemToRegE, WriteRegE, RtD);
    assign w_brstall = BranchD &&
                       (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD) ||
                        reg_hit(MemToRegM, WriteRegM, RsD) || reg_hit(MemToRegM, WriteRegM, RtD));
    assign w_mdstall = MdOpD && (MdBusy || MdStartE);
    assign w_stall   = w_lwstall || w_brstall || w_mdstall;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;
    // A held decode register cannot also be cleared, so stall masks flush.
    assign FlushD = PCSrcD && !w_stall;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LwStallCnt <= '0;
            BrStallCnt <= '0;
            MdStallCnt <= '0;
            FlushCnt   <= '0;
        end else begin
            if (w_lwstall) begin
                if (LwStallCnt != C_CNT_MAX) LwStallCnt <= LwStallCnt + 32'd1;
            end else if (w_brstall) begin
                if (BrStallCnt != C_CNT_MAX) BrStallCnt <= BrStallCnt + 32'd1;
            end else if (w_mdstall) begin
                if (MdStallCnt != C_CNT_MAX) MdStallCnt <= MdStallCnt + 32'd1;
            end
            if (FlushD && (FlushCnt != C_CNT_MAX)) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed scoreboard bench for pipe_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic       BranchD, PCSrcD, MdOpD, MdStartE, MdIsDivE;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone;
    logic [1:0] ForwardAE, ForwardBE;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MdOpD(MdOpD),
        .MdStartE(MdStartE), .MdIsDivE(MdIsDivE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    typedef struct packed {
        logic       stall;
        logic       flushd;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic cmp(input string tag, input string name, input logic [1:0] act, input logic [1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %0d, expected %0d", tag, name, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "StallF",    {1'b0, StallF},    {1'b0, e.stall});
            cmp(t, "StallD",    {1'b0, StallD},    {1'b0, e.stall});
            cmp(t, "FlushE",    {1'b0, FlushE},    {1'b0, e.stall});
            cmp(t, "FlushD",    {1'b0, FlushD},    {1'b0, e.flushd});
            cmp(t, "ForwardAE", ForwardAE,         e.fae);
            cmp(t, "ForwardBE", ForwardBE,         e.fbe);
            cmp(t, "ForwardAD", {1'b0, ForwardAD}, {1'b0, e.fad});
            cmp(t, "ForwardBD", {1'b0, ForwardBD}, {1'b0, e.fbd});
            cmp(t, "MdBusy",    {1'b0, MdBusy},    {1'b0, e.busy});
            cmp(t, "MdDone",    {1'b0, MdDone},    {1'b0, e.done});
        end
    end

    task automatic clr();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemToRegE = 1'b0; MemToRegM = 1'b0;
        BranchD = 1'b0; PCSrcD = 1'b0; MdOpD = 1'b0; MdStartE = 1'b0; MdIsDivE = 1'b0;
    endtask

    // Inputs are already applied for this cycle; queue the expectation and advance.
    task automatic chk(input string tag, input logic stall, input logic flushd,
                       input logic [1:0] fae, input logic [1:0] fbe,
                       input logic fad, input logic fbd, input logic busy, input logic done);
        exp_t e;
        e = '{stall: stall, flushd: flushd, fae: fae, fbe: fbe,
              fad: fad, fbd: fbd, busy: busy, done: done};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clr();
        @(posedge clk); #1;
        chk("reset", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        rst = 1'b1;

        // load-use: lw $2 in E, RsD=2
        clr(); MemToRegE = 1; RegWriteE = 1; WriteRegE = 5'd2; RsD = 5'd2;
        chk("lwstall", 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        clr(); MemToRegM = 1; RegWriteM = 1; WriteRegM = 5'd2; RsE = 5'd2; RsD = 5'd7;
        chk("lw_fwdM", 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);

        // M has priority over W
        clr(); RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5; RsE = 5'd5; RtE = 5'd5;
        chk("fwd_prio", 0, 0, 2'b10, 2'b10, 0, 0, 0, 0);
        WriteRegM = 5'd0;
        chk("fwd_W", 0, 0, 2'b01, 2'b01, 0, 0, 0, 0);
        clr(); RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd9; RsE = 5'd5; RtE = 5'd9;
        chk("fwd_mix", 0, 0, 2'b10, 2'b01, 0, 0, 0, 0);

        // branch hazards
        clr(); BranchD = 1; RsD = 5'd3; RegWriteE = 1; WriteRegE = 5'd3; PCSrcD = 1;
        chk("brstall", 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        clr(); BranchD = 1; RsD = 5'd3; RegWriteM = 1; WriteRegM = 5'd3; PCSrcD = 1;
        chk("br_fwdAD", 0, 1, 2'b00, 2'b00, 1, 0, 0, 0);
        clr(); BranchD = 1; RtD = 5'd4; MemToRegM = 1; RegWriteM = 1; WriteRegM = 5'd4;
        chk("br_loadM", 1, 0, 2'b00, 2'b00, 0, 1, 0, 0);
        clr(); PCSrcD = 1;
        chk("jump_flush", 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);

        // $0 is never a hazard
        clr(); BranchD = 1; MemToRegE = 1; RegWriteE = 1; RegWriteM = 1; MemToRegM = 1; RegWriteW = 1;
        chk("reg_zero", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // mult with mflo waiting in decode: 5 stalled cycles
        clr(); MdOpD = 1; MdStartE = 1;
        chk("mul_start", 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            clr(); MdOpD = 1;
            chk($sformatf("mul_c%0d", i), 1, 0, 2'b00, 2'b00, 0, 0, 1, (i == 4));
        end
        clr(); MdOpD = 1;
        chk("mul_after", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // back-to-back mults, with an illegal start while busy ignored
        clr(); MdStartE = 1;
        chk("b2b_s0", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        clr();
        chk("b2b_c1", 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        clr(); MdStartE = 1; MdIsDivE = 1;
        chk("b2b_ign", 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        clr();
        chk("b2b_c3", 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        clr(); MdStartE = 1;
        chk("b2b_s1", 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
        for (int i = 5; i <= 8; i++) begin
            clr();
            chk($sformatf("b2b_c%0d", i), 0, 0, 2'b00, 2'b00, 0, 0, 1, (i == 8));
        end
        clr();
        chk("b2b_idle", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // div aborted by async reset at cycle 10
        clr(); MdStartE = 1; MdIsDivE = 1;
        chk("div_start", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            clr();
            chk($sformatf("div_c%0d", i), 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        end
        clr(); rst = 1'b0;
        chk("div_rst", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        rst = 1'b1;

        clr(); MdStartE = 1;
        chk("mul2_start", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            clr();
            chk($sformatf("mul2_c%0d", i), 0, 0, 2'b00, 2'b00, 0, 0, 1, (i == 4));
        end
        clr();
        chk("mul2_idle", 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
